seg_disp_sched: RTL
===================

Name: seg_disp_sched

Overview:
- Scheduler that shares the two-digit hex seven-segment display between two byte requesters, e.g. A = TX data and B = RX data of the comm link.
- Arbitrates round-robin between the requesters and latches the granted byte.
- Drives the high and low nibbles to the nibble-to-segment decoder, then holds, blanks and releases the display.
- Sits between the comm datapath and the segment decoder.

Parameters:
- HOLD_CYCLES, 50000000: cycles a value is shown (seg_en high); must be >= 1.
- BLANK_CYCLES, 5000000: dark gap after each value; 0 means no gap.
- BLINK_HALF, 12500000: half-period of blink in cycles; used only with SEG_BLINK_EN; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_valid  in  1  requester A has a byte to show
- a_data  in  8  requester A byte
- a_ready  out  1  A accepted this cycle (transfer = a_valid & a_ready)
- b_valid  in  1  requester B has a byte to show
- b_data  in  8  requester B byte
- b_ready  out  1  B accepted this cycle
- seg_data_1  out  4  high nibble, to decoder digit 1
- seg_data_2  out  4  low nibble, to decoder digit 2
- seg_en  out  1  digit enable (SEG bit); 1 = digits lit
- disp_src  out  1  source of shown value, 0 = A, 1 = B; drives the DP
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values:
  - seg_data_1 = 0, seg_data_2 = 0, seg_en = 0, disp_src = 0, busy = 0.
  - a_ready = 0, b_ready = 0.
  - state = IDLE, counter = 0, last_grant = B, so A wins the first tie.
- Reset mid-operation: the next state is IDLE on the same edge. The pending value is discarded and seg_en is 0 on the next cycle.
- Outputs:
  - seg_data_1, seg_data_2, seg_en, disp_src and busy are registered.
  - a_ready and b_ready are combinational from state, valids and last_grant.
- Grant, evaluated in IDLE only:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - a_ready = (state == IDLE) & grant_A; b_ready = (state == IDLE) & grant_B.
  - At most one ready is high in any cycle. Ready is never high outside IDLE.
- Valid handling:
  - A requester may drop valid before it is granted; nothing is lost, because data is captured only on transfer.
  - Data is sampled only on the transfer edge.
- On a transfer, registered on the same edge:
  - seg_data_1 = data[7:4], seg_data_2 = data[3:0].
  - disp_src = winner, last_grant = winner, seg_en = 1, counter = 0, state = SHOW.
- State machine IDLE / SHOW / BLANK:
  - IDLE: seg_en = 0; seg_data and disp_src hold their last values. Go to SHOW on a transfer.
  - SHOW: seg_en = 1 for exactly HOLD_CYCLES cycles, with the counter counting 0..HOLD_CYCLES-1. At the terminal count go to BLANK if BLANK_CYCLES > 0, else to IDLE.
  - BLANK: seg_en = 0 for exactly BLANK_CYCLES cycles, then go to IDLE.
- Latency:
  - Transfer at edge N: seg_en is high from cycle N+1.
  - The earliest next transfer is cycle N + 1 + HOLD_CYCLES + BLANK_CYCLES.
- Counter: width $clog2(max(HOLD_CYCLES, BLANK_CYCLES, BLINK_HALF) + 1). It is cleared on every state change and never wraps within a state.
- Starvation-free: with both requesters continuously valid, grants strictly alternate A, B, A, ...

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - In SHOW, seg_en toggles every BLINK_HALF cycles, starting high on the first SHOW cycle.
  - A separate blink counter restarts on entry to SHOW.
  - SHOW duration is unchanged at HOLD_CYCLES.
  - seg_en is forced to 0 in IDLE and BLANK.
- Not defined:
  - seg_en is steady 1 throughout SHOW.
  - The blink counter logic is absent and BLINK_HALF is unused.

Test Plan:
All scenarios use HOLD_CYCLES = 4, BLANK_CYCLES = 2, BLINK_HALF = 1 unless stated; cycle 0 = transfer edge.
1. Reset held 3 cycles with a_valid = 1 -> a_ready = 0, seg_en = 0, seg_data = 0/0, busy = 0 throughout. First grant occurs the cycle after rst falls.
2. Single A, a_data = 0x3C -> a_ready high 1 cycle. Cycles 1-4: seg_data_1 = 3, seg_data_2 = C, seg_en = 1, disp_src = 0. Cycles 5-6: seg_en = 0. Cycle 7: IDLE, busy = 0.
3. a_valid = b_valid = 1 from reset, a_data = 0x12, b_data = 0xAB -> A granted at cycle 0, B at cycle 7 (disp_src = 1, nibbles A/B), A again at cycle 14. A ready and B ready are never high together.
4. Only B continuously valid with b_data = 0x5F, BLANK_CYCLES = 0 -> B re-granted every 5 cycles. seg_en pattern: 1,1,1,1,0 repeating.
5. rst pulsed during SHOW cycle 2 -> next cycle seg_en = 0, seg_data = 0/0, busy = 0. A pending a_valid is granted the cycle after rst falls, with A priority.
6. SEG_BLINK_EN defined, single A transfer -> seg_en over cycles 1-4 = 1,0,1,0. Cycles 5-6 = 0. Without the macro, cycles 1-4 = 1,1,1,1.

Source files
------------

// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing a two-digit seven-segment display between two byte requesters.
// Optional macro SEG_BLINK_EN makes the digits blink during the show interval.
module seg_disp_sched #(
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned BLANK_CYCLES = 5000000,
    parameter int unsigned BLINK_HALF   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic [3:0] seg_data_1,
    output logic [3:0] seg_data_2,
    output logic       seg_en,
    output logic       disp_src,
    output logic       busy
);

    localparam int unsigned MAX_HB  = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_HB > BLINK_HALF) ? MAX_HB : BLINK_HALF;
    localparam int unsigned CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHOW  = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_grant, last_grant_nxt;   // 1 = B was granted last
    logic [3:0]    seg_data_1_nxt, seg_data_2_nxt;
    logic          seg_en_nxt, disp_src_nxt, busy_nxt;
    logic          grant_a, grant_b;

`ifdef SEG_BLINK_EN
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
    logic [CW-1:0] bcnt, bcnt_nxt;
`endif

    // Round-robin grant; ready is suppressed while reset is asserted
    always_comb begin
        grant_a = (state == IDLE) & a_valid & (~b_valid | last_grant);
        grant_b = (state == IDLE) & b_valid & (~a_valid | ~last_grant);
        a_ready = grant_a & ~rst;
        b_ready = grant_b & ~rst;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        seg_data_1_nxt = seg_data_1;
        seg_data_2_nxt = seg_data_2;
        seg_en_nxt     = seg_en;
        disp_src_nxt   = disp_src;
`ifdef SEG_BLINK_EN
        bcnt_nxt       = bcnt;
`endif
        case (state)
            IDLE: begin
                seg_en_nxt = 1'b0;
                if (grant_a | grant_b) begin
                    state_nxt      = SHOW;
                    cnt_nxt        = '0;
                    last_grant_nxt = grant_b;
                    disp_src_nxt   = grant_b;
                    seg_data_1_nxt = grant_b ? b_data[7:4] : a_data[7:4];
                    seg_data_2_nxt = grant_b ? b_data[3:0] : a_data[3:0];
                    seg_en_nxt     = 1'b1;
`ifdef SEG_BLINK_EN
                    bcnt_nxt       = '0;
`endif
                end
            end
            SHOW: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt    = '0;
                    seg_en_nxt = 1'b0;
                    state_nxt  = (BLANK_CYCLES > 0) ? BLANK : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
`ifdef SEG_BLINK_EN
                    if (bcnt == BLINK_LAST) begin
                        bcnt_nxt   = '0;
                        seg_en_nxt = ~seg_en;
                    end else begin
                        bcnt_nxt = bcnt + CW'(1);
                    end
`endif
                end
            end
            BLANK: begin
                seg_en_nxt = 1'b0;
                if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                seg_en_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            seg_data_1 <= 4'd0;
            seg_data_2 <= 4'd0;
            seg_en     <= 1'b0;
            disp_src   <= 1'b0;
            busy       <= 1'b0;
`ifdef SEG_BLINK_EN
            bcnt       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            seg_data_1 <= seg_data_1_nxt;
            seg_data_2 <= seg_data_2_nxt;
            seg_en     <= seg_en_nxt;
            disp_src   <= disp_src_nxt;
            busy       <= busy_nxt;
`ifdef SEG_BLINK_EN
            bcnt       <= bcnt_nxt;
`endif
        end
    end

endmodule
